// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state type and data width.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Double-register the input; both flops come out of reset at RESET_VAL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_frontend.sv
// UART receive front end: 8N1 deframing with mid-bit sampling, a one-deep
// valid/ready output register, frame-error and overrun pulses, and a BREAK
// state that suppresses start detection while the line is held low.
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(UART_DATA_BITS);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(UART_DATA_BITS - 1);

  logic                      rxs;
  uart_state_t               state;
  logic [CW-1:0]             cnt;
  logic [BW-1:0]             bit_cnt;
  logic [UART_DATA_BITS-1:0] shift;

  logic half_done;
  logic bit_done;
  logic byte_done;
  logic stop_bad;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rxs)
  );

  assign half_done = (cnt == HALF_LAST);
  assign bit_done  = (cnt == BIT_LAST);
  assign byte_done = (state == ST_STOP) && bit_done && rxs;
  assign stop_bad  = (state == ST_STOP) && bit_done && !rxs;
  assign busy      = (state != ST_IDLE);

  // Deframing FSM: start qualification at half period, then one sample per bit period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (!rxs) state <= ST_START;
        end
        ST_START: begin
          if (half_done) begin
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= rxs ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            cnt   <= '0;
            shift <= {rxs, shift[UART_DATA_BITS-1:1]};
            if (bit_cnt == DATA_LAST) state <= ST_STOP;
            else bit_cnt <= bit_cnt + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            cnt   <= '0;
            state <= rxs ? ST_IDLE : ST_BREAK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_BREAK: begin
          if (rxs) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output register: load on a good stop bit when free or being drained, else flag overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= byte_done && rx_valid && !rx_ready;
      if (byte_done && (!rx_valid || rx_ready)) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Self-checking bench for uart_rx_frontend at CLKS_PER_BIT=16: directed
// scenarios plus randomized frames, compared each cycle against a
// sample-schedule model of the receiver.
module tb_uart_rx_frontend;

  localparam int unsigned N = 16;
  localparam int unsigned H = N / 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;

  uart_rx_frontend #(
    .CLKS_PER_BIT(N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: line value seen by the receiver lags rx by two edges; after a
  // start is seen at edge t0, the receiver samples at t0+H (start check),
  // t0+H+j*N for data bit j-1, and t0+H+9N for the stop bit.
  // Mode: 0 idle, 1 in frame, 2 break.
  int          m_mode;
  int unsigned k;
  int unsigned t0;
  int unsigned rel;
  logic        m_h1, m_h2, m_rxs;
  logic [7:0]  m_bits;
  logic [7:0]  m_data;
  logic        m_valid, m_fe, m_ov, m_got;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; k = 0; t0 = 0;
      m_h1 = 1'b1; m_h2 = 1'b1;
      m_bits = '0; m_data = '0;
      m_valid = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
    end else begin
      k++;
      m_rxs = m_h2;
      m_h2  = m_h1;
      m_h1  = rx;
      m_fe  = 1'b0;
      m_ov  = 1'b0;
      m_got = 1'b0;
      case (m_mode)
        0: if (!m_rxs) begin m_mode = 1; t0 = k; end
        1: begin
          rel = k - t0;
          if (rel == H) begin
            if (m_rxs) m_mode = 0;
          end else if (rel > H && rel <= H + 8 * N && (rel - H) % N == 0) begin
            m_bits[(rel - H) / N - 1] = m_rxs;
          end else if (rel == H + 9 * N) begin
            if (m_rxs) begin m_got = 1'b1; m_mode = 0; end
            else begin m_fe = 1'b1; m_mode = 2; end
          end
        end
        default: if (m_rxs) m_mode = 0;
      endcase
      if (m_got) begin
        if (!m_valid || rx_ready) begin m_data = m_bits; m_valid = 1'b1; end
        else m_ov = 1'b1;
      end else if (m_valid && rx_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Observed DUT activity, used by the directed literal checks.
  int         valid_rises, fe_cnt, ov_cnt, busy_cnt;
  logic       prev_valid = 1'b0;
  logic [7:0] acc[$];

  task automatic clear_obs();
    valid_rises = 0; fe_cnt = 0; ov_cnt = 0; busy_cnt = 0;
    acc.delete();
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("rx_valid", 32'(rx_valid), 32'(m_valid));
    check("busy", 32'(busy), 32'(m_mode != 0));
    check("frame_err", 32'(frame_err), 32'(m_fe));
    check("overrun", 32'(overrun), 32'(m_ov));
    if (m_valid) check("rx_data", 32'(rx_data), 32'(m_data));
    if (rx_valid && !prev_valid) valid_rises++;
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (busy) busy_cnt++;
    if (rx_valid && rx_ready) acc.push_back(rx_data);
    prev_valid = rx_valid;
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_val);
    rx = 1'b0;
    tick(N);
    for (int unsigned i = 0; i < 8; i++) begin
      rx = b[i];
      tick(N);
    end
    rx = stop_val;
    tick(N);
  endtask

  logic rand_en = 1'b0;

  // Random consumer back-pressure during the randomized phase.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_en) rx_ready = ($urandom_range(0, 2) != 0);
    end
  end

  int unsigned p;
  logic [7:0]  pre = 8'hC3;

  initial begin
    rx = 1'b1; rx_ready = 1'b0; rst = 1'b1;
    clear_obs();
    tick(3);
    check("reset rx_valid", 32'(rx_valid), 32'd0);
    check("reset rx_data", 32'(rx_data), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset frame_err", 32'(frame_err), 32'd0);
    check("reset overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    tick(5);

    // Clean frame 0xA5 with consumer always ready.
    rx_ready = 1'b1;
    clear_obs();
    send_frame(8'hA5, 1'b1);
    tick(N);
    check("a5 valid pulses", 32'(valid_rises), 32'd1);
    check("a5 accepted count", 32'(acc.size()), 32'd1);
    if (acc.size() > 0) check("a5 data", 32'(acc[0]), 32'hA5);
    check("a5 frame_err", 32'(fe_cnt), 32'd0);

    // 5-cycle low glitch: start rejected, busy for exactly H cycles.
    clear_obs();
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(2 * N);
    check("glitch busy cycles", 32'(busy_cnt), 32'd8);
    check("glitch valid", 32'(valid_rises), 32'd0);
    check("glitch frame_err", 32'(fe_cnt), 32'd0);

    // 0x3C with low stop bit, line held low: one frame_err, stuck in BREAK.
    clear_obs();
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    tick(40);
    check("break busy", 32'(busy), 32'd1);
    check("break frame_err count", 32'(fe_cnt), 32'd1);
    check("break valid", 32'(valid_rises), 32'd0);
    rx = 1'b1;
    tick(4);
    check("break exit busy", 32'(busy), 32'd0);
    tick(N);

    // 0x11 then 0x22 with no consumer: first held, second dropped.
    rx_ready = 1'b0;
    clear_obs();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(N);
    check("ovr valid held", 32'(rx_valid), 32'd1);
    check("ovr data held", 32'(rx_data), 32'h11);
    check("ovr pulses", 32'(ov_cnt), 32'd1);
    rx_ready = 1'b1;
    tick(2);
    rx_ready = 1'b0;
    check("ovr accepted count", 32'(acc.size()), 32'd1);
    if (acc.size() > 0) check("ovr accepted data", 32'(acc[0]), 32'h11);
    check("ovr drained", 32'(rx_valid), 32'd0);
    tick(N);

    // Reset in the middle of data bit 4, then a clean 0x5A.
    rx_ready = 1'b1;
    clear_obs();
    rx = 1'b0;
    tick(N);
    for (int unsigned i = 0; i < 4; i++) begin
      rx = pre[i];
      tick(N);
    end
    rx = pre[4];
    tick(H);
    rst = 1'b1;
    #1;
    check("mid rst busy", 32'(busy), 32'd0);
    check("mid rst valid", 32'(rx_valid), 32'd0);
    check("mid rst data", 32'(rx_data), 32'd0);
    tick(2);
    rx = 1'b1;
    rst = 1'b0;
    tick(2 * N);
    check("post rst busy", 32'(busy), 32'd0);
    check("post rst valid", 32'(valid_rises), 32'd0);
    check("post rst frame_err", 32'(fe_cnt), 32'd0);
    send_frame(8'h5A, 1'b1);
    tick(N);
    check("5a accepted count", 32'(acc.size()), 32'd1);
    if (acc.size() > 0) check("5a data", 32'(acc[0]), 32'h5A);

    // 0x77 delivered over pending 0x66 in the very cycle 0x66 is accepted.
    rx_ready = 1'b0;
    clear_obs();
    send_frame(8'h66, 1'b1);
    tick(N);
    check("66 pending", 32'(rx_data), 32'h66);
    p = cyc;
    fork
      send_frame(8'h77, 1'b1);
      begin
        while (cyc < p + 2 + H + 9 * N) tick(1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
      end
    join
    tick(N);
    check("77 valid", 32'(rx_valid), 32'd1);
    check("77 data", 32'(rx_data), 32'h77);
    check("77 overrun", 32'(ov_cnt), 32'd0);
    check("66 accepted count", 32'(acc.size()), 32'd1);
    if (acc.size() > 0) check("66 accepted data", 32'(acc[0]), 32'h66);
    rx_ready = 1'b1;
    tick(2);

    // Randomized traffic: bytes, bad stop bits, glitches, random back-pressure.
    rand_en = 1'b1;
    for (int unsigned f = 0; f < 40; f++) begin
      logic [7:0] b;
      logic       sv;
      b  = 8'($urandom);
      sv = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) begin
        rx = 1'b0;
        tick($urandom_range(1, H - 2));
        rx = 1'b1;
        tick(N);
      end
      send_frame(b, sv);
      if (!sv) begin
        rx = 1'b0;
        tick($urandom_range(0, 30));
        rx = 1'b1;
        tick(2);
      end
      rx = 1'b1;
      tick($urandom_range(0, 20));
    end
    rand_en = 1'b0;
    rx_ready = 1'b1;
    tick(3 * N);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
